// File: rtl/wb_arbiter.sv
// Round-robin writeback arbiter: three vector producers share one
// register-file write port, one element per accepted handshake.
module wb_arbiter (
  input  logic         clk,
  input  logic         reset,
  input  logic [2:0]   wb_req,
  input  logic [14:0]  wb_vreg,
  input  logic [20:0]  wb_vlen,
  input  logic [2:0]   wb_elem_valid,
  input  logic [191:0] wb_elem_data,
  input  logic         rf_wr_ready,
  output logic [2:0]   wb_grant,
  output logic [2:0]   wb_elem_ready,
  output logic [2:0]   wb_done,
  output logic         rf_we,
  output logic [4:0]   rf_vreg,
  output logic [5:0]   rf_elem,
  output logic [63:0]  rf_wdata
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] XFER = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state;
  logic [1:0]  rr_ptr;
  logic [1:0]  gidx;
  logic [1:0]  pick;
  logic [1:0]  ofs;
  logic [2:0]  rot;
  logic [2:0]  sum;
  logic [4:0]  vreg_q;
  logic [4:0]  vreg_in;
  logic [6:0]  vlen_q;
  logic [6:0]  vlen_raw;
  logic [6:0]  vlen_in;
  logic [6:0]  cnt;
  logic [63:0] edata;
  logic        hs;

  // rot[k] is the request of the requester k places after rr_ptr
  always_comb begin
    case (rr_ptr)
      2'd1:    rot = {wb_req[0], wb_req[2], wb_req[1]};
      2'd2:    rot = {wb_req[1], wb_req[0], wb_req[2]};
      default: rot = wb_req;
    endcase
    if (rot[0])      ofs = 2'd0;
    else if (rot[1]) ofs = 2'd1;
    else             ofs = 2'd2;
    sum  = {1'b0, rr_ptr} + {1'b0, ofs};
    pick = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
  end

  always_comb begin
    vreg_in  = wb_vreg[4:0];
    vlen_raw = wb_vlen[6:0];
    case (pick)
      2'd1: begin
        vreg_in  = wb_vreg[9:5];
        vlen_raw = wb_vlen[13:7];
      end
      2'd2: begin
        vreg_in  = wb_vreg[14:10];
        vlen_raw = wb_vlen[20:14];
      end
      default: ;
    endcase
    vlen_in = (vlen_raw > 7'd64) ? 7'd64 : vlen_raw;
  end

  always_comb begin
    case (gidx)
      2'd1:    edata = wb_elem_data[127:64];
      2'd2:    edata = wb_elem_data[191:128];
      default: edata = wb_elem_data[63:0];
    endcase
  end

  assign wb_elem_ready = (state == XFER && rf_wr_ready) ? wb_grant : 3'b000;
  assign hs = |(wb_elem_valid & wb_elem_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      rr_ptr   <= 2'd0;
      gidx     <= 2'd0;
      cnt      <= 7'd0;
      vreg_q   <= 5'd0;
      vlen_q   <= 7'd0;
      wb_grant <= 3'b000;
      wb_done  <= 3'b000;
      rf_we    <= 1'b0;
      rf_vreg  <= 5'd0;
      rf_elem  <= 6'd0;
      rf_wdata <= 64'd0;
    end else begin
      rf_we   <= hs;
      wb_done <= 3'b000;
      if (hs) begin
        rf_vreg  <= vreg_q;
        rf_elem  <= cnt[5:0];
        rf_wdata <= edata;
      end
      case (state)
        IDLE: begin
          if (|wb_req) begin
            gidx     <= pick;
            wb_grant <= 3'b001 << pick;
            vreg_q   <= vreg_in;
            vlen_q   <= vlen_in;
            cnt      <= 7'd0;
            state    <= (vlen_in == 7'd0) ? DONE : XFER;
          end
        end
        XFER: begin
          if (hs) begin
            cnt <= cnt + 7'd1;
            if (cnt == vlen_q - 7'd1) state <= DONE;
          end
        end
        DONE: begin
          wb_done  <= wb_grant;
          wb_grant <= 3'b000;
          rr_ptr   <= (gidx == 2'd2) ? 2'd0 : gidx + 2'd1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: random producers and a
// transaction-level round-robin model of expected grants and writes.
module tb_wb_arbiter;
  logic         clk = 1'b0;
  logic         reset;
  logic [2:0]   wb_req;
  logic [14:0]  wb_vreg;
  logic [20:0]  wb_vlen;
  logic [2:0]   wb_elem_valid;
  logic [191:0] wb_elem_data;
  logic         rf_wr_ready;
  logic [2:0]   wb_grant;
  logic [2:0]   wb_elem_ready;
  logic [2:0]   wb_done;
  logic         rf_we;
  logic [4:0]   rf_vreg;
  logic [5:0]   rf_elem;
  logic [63:0]  rf_wdata;

  wb_arbiter dut (
    .clk(clk), .reset(reset), .wb_req(wb_req), .wb_vreg(wb_vreg),
    .wb_vlen(wb_vlen), .wb_elem_valid(wb_elem_valid),
    .wb_elem_data(wb_elem_data), .rf_wr_ready(rf_wr_ready),
    .wb_grant(wb_grant), .wb_elem_ready(wb_elem_ready),
    .wb_done(wb_done), .rf_we(rf_we), .rf_vreg(rf_vreg),
    .rf_elem(rf_elem), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  vreg;
    logic [5:0]  elem;
    logic [63:0] data;
  } wr_t;
  typedef struct packed {
    int         cyc;
    logic [2:0] bits;
  } ev_t;

  wr_t        wr_q[$];
  wr_t        exp_wr[$];
  int         wr_cyc[$];
  ev_t        gnt_q[$];
  ev_t        done_q[$];
  logic [2:0] exp_g[$];
  int         cyc, n_cmp, n_bad, rdy_viol, m_ptr;
  int         pidx[3];
  logic [31:0] tseed;
  logic [2:0] prev_gnt;
  logic [6:0] vl[3];
  logic [4:0] vr[3];

  function automatic logic [63:0] pat(int i, int k);
    return {tseed, 24'(i), 8'(k)};
  endfunction

  // Expected grants and writes from the round-robin rule alone
  function automatic void model(input logic [2:0] req, input int ng);
    exp_wr.delete();
    exp_g.delete();
    for (int n = 0; n < ng; n++) begin
      int g;
      int len;
      wr_t w;
      g = -1;
      for (int k = 0; k < 3; k++)
        if (g < 0 && req[(m_ptr + k) % 3]) g = (m_ptr + k) % 3;
      exp_g.push_back(3'(1 << g));
      len = (vl[g] > 7'd64) ? 64 : int'(vl[g]);
      for (int e = 0; e < len; e++) begin
        w.vreg = vr[g];
        w.elem = 6'(e);
        w.data = pat(g, e);
        exp_wr.push_back(w);
      end
      m_ptr = (g + 1) % 3;
    end
  endfunction

  function automatic int wr_diff();
    if (wr_q.size() != exp_wr.size()) return -2;
    foreach (wr_q[j]) if (wr_q[j] !== exp_wr[j]) return j;
    return -1;
  endfunction

  function automatic int ev_diff(input int which);
    if (which == 0) begin
      if (gnt_q.size() != exp_g.size()) return -2;
      foreach (gnt_q[j]) if (gnt_q[j].bits !== exp_g[j]) return j;
    end else begin
      if (done_q.size() != exp_g.size()) return -2;
      foreach (done_q[j]) if (done_q[j].bits !== exp_g[j]) return j;
    end
    return -1;
  endfunction

  task automatic apply_cfg();
    for (int i = 0; i < 3; i++) begin
      wb_vreg[i*5 +: 5] = vr[i];
      wb_vlen[i*7 +: 7] = vl[i];
    end
  endtask

  task automatic clr();
    wr_q.delete();
    wr_cyc.delete();
    gnt_q.delete();
    done_q.delete();
    rdy_viol = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wb_req = 3'b000;
    wb_elem_valid = 3'b000;
    rf_wr_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) pidx[i] = 0;
    m_ptr = 0;
    prev_gnt = 3'b000;
    tseed = $urandom;
    clr();
  endtask

  // One cycle: log registered outputs, drive producers, note handshakes
  task automatic step(input int vp, input int rp);
    wr_t w;
    ev_t e;
    @(negedge clk);
    cyc++;
    if (rf_we) begin
      w.vreg = rf_vreg;
      w.elem = rf_elem;
      w.data = rf_wdata;
      wr_q.push_back(w);
      wr_cyc.push_back(cyc);
    end
    if (wb_grant != 3'b000 && prev_gnt == 3'b000) begin
      e.cyc = cyc;
      e.bits = wb_grant;
      gnt_q.push_back(e);
    end
    prev_gnt = wb_grant;
    if (wb_done != 3'b000) begin
      e.cyc = cyc;
      e.bits = wb_done;
      done_q.push_back(e);
      for (int i = 0; i < 3; i++) if (wb_done[i]) pidx[i] = 0;
    end
    for (int i = 0; i < 3; i++) begin
      wb_elem_valid[i] = int'($urandom_range(0, 99)) < vp;
      wb_elem_data[i*64 +: 64] = pat(i, pidx[i]);
    end
    rf_wr_ready = int'($urandom_range(0, 99)) < rp;
    #1;
    if ((wb_elem_ready & ~wb_grant) != 3'b000 ||
        (!rf_wr_ready && wb_elem_ready != 3'b000)) rdy_viol++;
    for (int i = 0; i < 3; i++)
      if (wb_elem_valid[i] && wb_elem_ready[i]) pidx[i]++;
  endtask

  // Run until ng transfers finish; inputs change after the last grant
  task automatic run(input int ng, input int vp, input int rp,
                     input int budget, output bit to);
    int n;
    n = 0;
    to = 1'b0;
    while (done_q.size() < ng && n < budget) begin
      step(vp, rp);
      n++;
      if (gnt_q.size() >= ng) begin
        wb_req = 3'b000;
        wb_vreg = 15'($urandom);
        wb_vlen = 21'($urandom);
      end
    end
    if (done_q.size() < ng) to = 1'b1;
    step(vp, rp);
    step(vp, rp);
  endtask

  task automatic chk_xfer(input string nm, input bit to);
    int d;
    n_cmp++;
    if (to !== 1'b0) begin
      n_bad++;
      $display("FAIL %s timeout: done %0d want %0d", nm, done_q.size(), exp_g.size());
    end
    d = ev_diff(0);
    n_cmp++;
    if (d !== -1) begin
      n_bad++;
      $display("FAIL %s grant: idx %0d got %0d grants want %0d", nm, d, gnt_q.size(), exp_g.size());
    end
    d = ev_diff(1);
    n_cmp++;
    if (d !== -1) begin
      n_bad++;
      $display("FAIL %s done: idx %0d got %0d pulses want %0d", nm, d, done_q.size(), exp_g.size());
    end
    d = wr_diff();
    n_cmp++;
    if (d !== -1) begin
      n_bad++;
      $display("FAIL %s writes: idx %0d got %0d writes want %0d", nm, d, wr_q.size(), exp_wr.size());
      if (d >= 0)
        $display("  got %h want %h", wr_q[d], exp_wr[d]);
    end
    n_cmp++;
    if (rdy_viol !== 0) begin
      n_bad++;
      $display("FAIL %s elem_ready: got %0d illegal cycles want 0", nm, rdy_viol);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({wb_grant, wb_done, wb_elem_ready, rf_we, rf_vreg, rf_elem, rf_wdata} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: grant %b done %b we %b elem %0d got nonzero want 0",
               wb_grant, wb_done, rf_we, rf_elem);
    end
    do_reset();
  endtask

  task automatic test_single();
    bit to;
    do_reset();
    vr = '{5'd5, 5'd0, 5'd0};
    vl = '{7'd4, 7'd0, 7'd0};
    apply_cfg();
    model(3'b001, 1);
    wb_req = 3'b001;
    run(1, 100, 100, 100, to);
    chk_xfer("single", to);
    n_cmp++;
    if (wr_cyc.size() != 4 || done_q.size() != 1 ||
        done_q[0].cyc !== wr_cyc[3] + 1 || wr_cyc[3] - wr_cyc[0] !== 3) begin
      n_bad++;
      $display("FAIL single_timing: got %0d writes want 4 back-to-back, done one cycle after last", wr_cyc.size());
    end
  endtask

  task automatic test_round_robin();
    bit to;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      vr[i] = 5'($urandom);
      vl[i] = 7'd2;
    end
    apply_cfg();
    model(3'b111, 4);
    wb_req = 3'b111;
    run(4, 100, 100, 200, to);
    chk_xfer("round_robin", to);
    for (int j = 0; j < 3; j++) begin
      n_cmp++;
      if (gnt_q.size() != 4 || done_q.size() != 4 ||
          gnt_q[j+1].cyc !== done_q[j].cyc + 1) begin
        n_bad++;
        $display("FAIL rr_gap%0d: got %0d grants/%0d dones want next grant one cycle after done",
                 j, gnt_q.size(), done_q.size());
      end
    end
  endtask

  task automatic test_backpressure();
    int stalls;
    do_reset();
    vr[0] = 5'($urandom);
    vl[0] = 7'd3;
    apply_cfg();
    model(3'b001, 1);
    wb_req = 3'b001;
    stalls = 0;
    for (int t = 0; t < 20; t++) begin
      step(100, (t >= 2 && t <= 4) ? 0 : 100);
      if (gnt_q.size() >= 1) wb_req = 3'b000;
      if (!rf_wr_ready && wb_grant != 3'b000) stalls++;
    end
    chk_xfer("backpressure", 1'b0);
    n_cmp++;
    if (stalls !== 3) begin
      n_bad++;
      $display("FAIL bp_stall: got %0d stalled granted cycles want 3", stalls);
    end
  endtask

  task automatic test_vlen0();
    bit to;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      vr[i] = 5'($urandom);
      vl[i] = 7'd1;
    end
    vl[2] = 7'd0;
    apply_cfg();
    model(3'b100, 1);
    wb_req = 3'b100;
    run(1, 100, 100, 50, to);
    chk_xfer("vlen0", to);
    n_cmp++;
    if (gnt_q.size() != 1 || done_q.size() != 1 ||
        done_q[0].cyc !== gnt_q[0].cyc + 1) begin
      n_bad++;
      $display("FAIL vlen0_timing: got %0d grants %0d dones want done right after grant",
               gnt_q.size(), done_q.size());
    end
    clr();
    apply_cfg();
    model(3'b111, 1);
    wb_req = 3'b111;
    run(1, 100, 100, 50, to);
    chk_xfer("vlen0_ptr", to);
  endtask

  task automatic test_reset_mid();
    bit to;
    int n;
    do_reset();
    vr[0] = 5'($urandom);
    vl[0] = 7'd8;
    apply_cfg();
    wb_req = 3'b001;
    n = 0;
    while (wr_q.size() < 2 && n < 50) begin
      step(100, 100);
      n++;
      if (gnt_q.size() >= 1) wb_req = 3'b000;
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({wb_grant, wb_done, wb_elem_ready, rf_we, rf_vreg, rf_elem, rf_wdata} !== '0 ||
        wr_q.size() != 2) begin
      n_bad++;
      $display("FAIL reset_mid: grant %b we %b elem %0d writes %0d got nonzero want 0 after 2 writes",
               wb_grant, rf_we, rf_elem, wr_q.size());
    end
    step(100, 100);
    step(100, 100);
    reset = 1'b0;
    step(0, 100);
    step(0, 100);
    n_cmp++;
    if (done_q.size() !== 0 || wr_q.size() !== 2) begin
      n_bad++;
      $display("FAIL reset_nodone: got %0d dones %0d writes want 0 and 2", done_q.size(), wr_q.size());
    end
    clr();
    for (int i = 0; i < 3; i++) pidx[i] = 0;
    m_ptr = 0;
    for (int i = 0; i < 3; i++) vl[i] = 7'($urandom_range(1, 6));
    apply_cfg();
    model(3'b110, 1);
    wb_req = 3'b110;
    run(1, 100, 100, 100, to);
    chk_xfer("reset_restart", to);
  endtask

  task automatic test_vlen64();
    bit to;
    int i;
    do_reset();
    i = int'($urandom_range(0, 2));
    for (int k = 0; k < 3; k++) begin
      vr[k] = 5'($urandom);
      vl[k] = 7'd64;
    end
    apply_cfg();
    model(3'(1 << i), 1);
    wb_req = 3'(1 << i);
    run(1, 60, 80, 1000, to);
    chk_xfer("vlen64", to);
  endtask

  task automatic test_random();
    bit to;
    int ng;
    logic [2:0] req;
    for (int it = 0; it < 6; it++) begin
      clr();
      for (int i = 0; i < 3; i++) begin
        vr[i] = 5'($urandom);
        vl[i] = 7'($urandom_range(0, 100));
      end
      apply_cfg();
      req = 3'($urandom_range(1, 7));
      ng = int'($urandom_range(1, 4));
      model(req, ng);
      wb_req = req;
      run(ng, int'($urandom_range(50, 100)), int'($urandom_range(50, 100)), 4000, to);
      chk_xfer("random", to);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    cyc = 0;
    rdy_viol = 0;
    m_ptr = 0;
    tseed = 32'h0;
    prev_gnt = 3'b000;
    for (int i = 0; i < 3; i++) begin
      pidx[i] = 0;
      vl[i] = 7'd0;
      vr[i] = 5'd0;
    end
    reset = 1'b1;
    wb_req = 3'b000;
    wb_vreg = 15'd0;
    wb_vlen = 21'd0;
    wb_elem_valid = 3'b000;
    wb_elem_data = 192'd0;
    rf_wr_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_vlen0();
    test_reset_mid();
    test_vlen64();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
